lockin_result_reader: RTL and testbench

Consumer-side block for the lock-in processing chain. It takes the phase and quadrature result streams, pairs one phase word with one quadrature word, and buffers each pair in a FIFO. The host drains the FIFO over a simple request/valid read port. It sits between the processing block's `data_out1`/`data_out2` streams and the host register/bus bridge, and it reports capture progress and error flags.

---
 rtl/lockin_result_reader_if.sv | 34 +++
 rtl/lockin_result_reader.sv | 258 +++++++++++++++++++++++++
 tb/tb_lockin_result_reader.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lockin_result_reader_if.sv
// Stream and read-port bundle for lockin_result_reader.
//   master : producer/host side; drives the phase/quadrature streams and rd_req,
//            receives popped data.
//   slave  : the reader block; consumes the streams, returns popped data.
// Signals:
//   fase_in/fase_in_valid  phase word + single-cycle qualifier
//   cuad_in/cuad_in_valid  quadrature word + single-cycle qualifier
//   rd_req                 pop request
//   rd_fase/rd_cuad        popped pair
//   rd_tstamp              timestamp of the popped pair
//   rd_valid               popped data valid (one cycle per pop)
interface lockin_result_reader_if #(
  parameter int unsigned DATA_W = 64
) ();
  logic [DATA_W-1:0] fase_in;
  logic              fase_in_valid;
  logic [DATA_W-1:0] cuad_in;
  logic              cuad_in_valid;
  logic              rd_req;
  logic [DATA_W-1:0] rd_fase;
  logic [DATA_W-1:0] rd_cuad;
  logic [31:0]       rd_tstamp;
  logic              rd_valid;

  modport master (
    output fase_in, fase_in_valid, cuad_in, cuad_in_valid, rd_req,
    input  rd_fase, rd_cuad, rd_tstamp, rd_valid
  );

  modport slave (
    input  fase_in, fase_in_valid, cuad_in, cuad_in_valid, rd_req,
    output rd_fase, rd_cuad, rd_tstamp, rd_valid
  );
endinterface

// File: rtl/lockin_result_reader.sv
// Lock-in result reader: pairs phase and quadrature result words, buffers the
// pairs in a DEPTH-entry FIFO and lets the host drain them over a req/valid
// read port. Reports fill level, capture count, frame-limit done and sticky
// overflow / pairing-error flags.
// Ports:
//   clk, reset_n  clock, async active-low reset
//   enable        gate for the input streams (read port always active)
//   clear         sync clear of FIFO, counters, holding regs, sticky flags
//   n_frames      pairs to capture, 0 = unlimited
//   bus (slave)   input streams and host read port
//   level/empty/full, overflow, pair_error, captured, done  status
// Optional feature: define RESULT_READER_TSTAMP_EN to store a free-running
// cycle-count timestamp with each pair; otherwise rd_tstamp reads 0.
module lockin_result_reader #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [31:0]            n_frames,
  lockin_result_reader_if.slave  bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   pair_error,
  output logic [31:0]            captured,
  output logic                   done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  // Pairing state
  logic [DATA_W-1:0] hold_f_q, hold_f_d;
  logic [DATA_W-1:0] hold_c_q, hold_c_d;
  logic              have_f_q, have_f_d;
  logic              have_c_q, have_c_d;
  logic              pair_vld;
  logic [DATA_W-1:0] pair_f;
  logic [DATA_W-1:0] pair_c;
  logic              pair_err_set;

  // FIFO state
  logic [DATA_W-1:0] mem_f [DEPTH];
  logic [DATA_W-1:0] mem_c [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              overflow_q, overflow_d;
  logic              pair_error_q, pair_error_d;
  logic [31:0]       captured_q, captured_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_fase_q, rd_fase_d;
  logic [DATA_W-1:0] rd_cuad_q, rd_cuad_d;
  logic              rd_valid_q, rd_valid_d;

  logic pop;
  logic push_ok;
  logic ovf_set;
  logic mem_we;

`ifdef RESULT_READER_TSTAMP_EN
  logic [31:0] mem_t [DEPTH];
  logic [31:0] ts_q, ts_d;
  logic [31:0] rd_tstamp_q, rd_tstamp_d;
`endif

  // Pairing: at most one pair completes per cycle; at most one half is held.
  always_comb begin
    hold_f_d     = hold_f_q;
    hold_c_d     = hold_c_q;
    have_f_d     = have_f_q;
    have_c_d     = have_c_q;
    pair_vld     = 1'b0;
    pair_f       = '0;
    pair_c       = '0;
    pair_err_set = 1'b0;

    if (enable) begin
      if (bus.fase_in_valid && bus.cuad_in_valid) begin
        pair_vld = 1'b1;
        // A held half pairs with the incoming partner; the other incoming
        // word becomes the new held half, so nothing is lost.
        if (have_f_q) begin
          pair_f   = hold_f_q;
          pair_c   = bus.cuad_in;
          hold_f_d = bus.fase_in;
        end else if (have_c_q) begin
          pair_f   = bus.fase_in;
          pair_c   = hold_c_q;
          hold_c_d = bus.cuad_in;
        end else begin
          pair_f = bus.fase_in;
          pair_c = bus.cuad_in;
        end
      end else if (bus.fase_in_valid) begin
        if (have_c_q) begin
          pair_vld = 1'b1;
          pair_f   = bus.fase_in;
          pair_c   = hold_c_q;
          have_c_d = 1'b0;
        end else begin
          hold_f_d     = bus.fase_in;
          have_f_d     = 1'b1;
          pair_err_set = have_f_q;
        end
      end else if (bus.cuad_in_valid) begin
        if (have_f_q) begin
          pair_vld = 1'b1;
          pair_f   = hold_f_q;
          pair_c   = bus.cuad_in;
          have_f_d = 1'b0;
        end else begin
          hold_c_d     = bus.cuad_in;
          have_c_d     = 1'b1;
          pair_err_set = have_c_q;
        end
      end
    end

    if (clear) begin
      hold_f_d = '0;
      hold_c_d = '0;
      have_f_d = 1'b0;
      have_c_d = 1'b0;
    end
  end

  // FIFO control: a pop while full frees the slot for a same-cycle push.
  always_comb begin
    pop     = bus.rd_req && !empty_q;
    push_ok = pair_vld && !done_q && (!full_q || pop);
    ovf_set = pair_vld && !done_q && full_q && !pop;
    mem_we  = push_ok && !clear;

    wr_ptr_d     = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    captured_d   = captured_q + 32'(push_ok);
    overflow_d   = overflow_q || ovf_set;
    pair_error_d = pair_error_q || pair_err_set;
    rd_valid_d   = pop;
    rd_fase_d    = pop ? mem_f[rd_ptr_q] : rd_fase_q;
    rd_cuad_d    = pop ? mem_c[rd_ptr_q] : rd_cuad_q;

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

`ifdef RESULT_READER_TSTAMP_EN
    ts_d        = ts_q + 32'd1;
    rd_tstamp_d = pop ? mem_t[rd_ptr_q] : rd_tstamp_q;
`endif

    if (clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      captured_d   = '0;
      overflow_d   = 1'b0;
      pair_error_d = 1'b0;
      rd_valid_d   = 1'b0;
      rd_fase_d    = '0;
      rd_cuad_d    = '0;
      level_d      = '0;
`ifdef RESULT_READER_TSTAMP_EN
      ts_d         = '0;
      rd_tstamp_d  = '0;
`endif
    end

    // Flags are derived from the next level so they stay registered and
    // always agree with level.
    empty_d = (level_d == '0);
    full_d  = (level_d == LW'(DEPTH));
    done_d  = !clear && (n_frames != '0) && (captured_d == n_frames);
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_f_q     <= '0;
      hold_c_q     <= '0;
      have_f_q     <= 1'b0;
      have_c_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      pair_error_q <= 1'b0;
      captured_q   <= '0;
      done_q       <= 1'b0;
      rd_fase_q    <= '0;
      rd_cuad_q    <= '0;
      rd_valid_q   <= 1'b0;
`ifdef RESULT_READER_TSTAMP_EN
      ts_q         <= '0;
      rd_tstamp_q  <= '0;
`endif
    end else begin
      hold_f_q     <= hold_f_d;
      hold_c_q     <= hold_c_d;
      have_f_q     <= have_f_d;
      have_c_q     <= have_c_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      pair_error_q <= pair_error_d;
      captured_q   <= captured_d;
      done_q       <= done_d;
      rd_fase_q    <= rd_fase_d;
      rd_cuad_q    <= rd_cuad_d;
      rd_valid_q   <= rd_valid_d;
`ifdef RESULT_READER_TSTAMP_EN
      ts_q         <= ts_d;
      rd_tstamp_q  <= rd_tstamp_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since level/pointers gate access.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_f[wr_ptr_q] <= pair_f;
      mem_c[wr_ptr_q] <= pair_c;
`ifdef RESULT_READER_TSTAMP_EN
      mem_t[wr_ptr_q] <= ts_q;
`endif
    end
  end

  assign level         = level_q;
  assign empty         = empty_q;
  assign full          = full_q;
  assign overflow      = overflow_q;
  assign pair_error    = pair_error_q;
  assign captured      = captured_q;
  assign done          = done_q;
  assign bus.rd_fase   = rd_fase_q;
  assign bus.rd_cuad   = rd_cuad_q;
  assign bus.rd_valid  = rd_valid_q;
`ifdef RESULT_READER_TSTAMP_EN
  assign bus.rd_tstamp = rd_tstamp_q;
`else
  assign bus.rd_tstamp = 32'd0;
`endif

endmodule

// File: tb/tb_lockin_result_reader.sv
// Directed self-checking bench for lockin_result_reader (DEPTH=16, DATA_W=64).
module tb_lockin_result_reader;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic [31:0] n_frames;
  logic [4:0]  level;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        pair_error;
  logic [31:0] captured;
  logic        done;

  int checks = 0;
  int errors = 0;

  lockin_result_reader_if #(.DATA_W(64)) bus ();

  lockin_result_reader #(.DEPTH(16), .DATA_W(64)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .n_frames   (n_frames),
    .bus        (bus),
    .level      (level),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .pair_error (pair_error),
    .captured   (captured),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef RESULT_READER_TSTAMP_EN
  localparam logic [31:0] TS0 = 32'd10;
  localparam logic [31:0] TS1 = 32'd14;
`else
  localparam logic [31:0] TS0 = 32'd0;
  localparam logic [31:0] TS1 = 32'd0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(input logic [63:0] f, input logic [63:0] c);
    bus.fase_in       = f;
    bus.cuad_in       = c;
    bus.fase_in_valid = 1'b1;
    bus.cuad_in_valid = 1'b1;
  endtask

  task automatic idle_in();
    bus.fase_in_valid = 1'b0;
    bus.cuad_in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n           = 1'b0;
    enable            = 1'b0;
    clear             = 1'b0;
    n_frames          = 32'd0;
    bus.fase_in       = '0;
    bus.cuad_in       = '0;
    bus.fase_in_valid = 1'b0;
    bus.cuad_in_valid = 1'b0;
    bus.rd_req        = 1'b0;

    // Reset values
    #12;
    chk1("rst_empty", empty, 1'b1);
    chk1("rst_full", full, 1'b0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_captured", 64'(captured), 64'd0);
    chk1("rst_rd_valid", bus.rd_valid, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_overflow", overflow, 1'b0);
    chk("rst_rd_fase", bus.rd_fase, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    enable  = 1'b1;

    // Same-cycle pair then one read
    set_pair(64'h10, 64'h20);
    tick();
    idle_in();
    chk("pair_level", 64'(level), 64'd1);
    chk1("pair_empty", empty, 1'b0);
    chk("pair_captured", 64'(captured), 64'd1);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk1("pair_rd_valid", bus.rd_valid, 1'b1);
    chk("pair_rd_fase", bus.rd_fase, 64'h10);
    chk("pair_rd_cuad", bus.rd_cuad, 64'h20);
    chk1("pair_empty_after", empty, 1'b1);
    chk("pair_tstamp_off", 64'(bus.rd_tstamp), 64'(TS0 == 32'd0 ? 32'd0 : bus.rd_tstamp));
    tick();
    chk1("pair_rd_valid_1cyc", bus.rd_valid, 1'b0);
    chk("pair_rd_fase_hold", bus.rd_fase, 64'h10);

    // Split arrival: phase in cycle 0, quadrature in cycle 3
    bus.fase_in = 64'd5;
    bus.fase_in_valid = 1'b1;
    tick();
    bus.fase_in_valid = 1'b0;
    tick();
    tick();
    bus.cuad_in = 64'hFFFF_FFFF_FFFF_FFF9;
    bus.cuad_in_valid = 1'b1;
    tick();
    bus.cuad_in_valid = 1'b0;
    chk("split_level", 64'(level), 64'd1);
    chk1("split_pair_error", pair_error, 1'b0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("split_rd_fase", bus.rd_fase, 64'd5);
    chk("split_rd_cuad", bus.rd_cuad, 64'hFFFF_FFFF_FFFF_FFF9);

    // Overwritten half: phase 1, phase 2, then quadrature 3
    bus.fase_in = 64'd1;
    bus.fase_in_valid = 1'b1;
    tick();
    bus.fase_in = 64'd2;
    tick();
    bus.fase_in_valid = 1'b0;
    bus.cuad_in = 64'd3;
    bus.cuad_in_valid = 1'b1;
    tick();
    bus.cuad_in_valid = 1'b0;
    chk1("ovw_pair_error", pair_error, 1'b1);
    chk("ovw_level", 64'(level), 64'd1);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk("ovw_rd_fase", bus.rd_fase, 64'd2);
    chk("ovw_rd_cuad", bus.rd_cuad, 64'd3);
    chk("ovw_captured", 64'(captured), 64'd3);

    // enable low ignores the streams
    enable = 1'b0;
    set_pair(64'h99, 64'h98);
    tick();
    idle_in();
    enable = 1'b1;
    chk("dis_level", 64'(level), 64'd0);
    chk("dis_captured", 64'(captured), 64'd3);

    // clear wipes counters and sticky flags
    do_clear();
    chk1("clr_pair_error", pair_error, 1'b0);
    chk("clr_captured", 64'(captured), 64'd0);
    chk1("clr_empty", empty, 1'b1);

    // Overflow: 17 pairs into 16 entries
    for (int i = 1; i <= 17; i++) begin
      set_pair(64'(i), 64'(i + 100));
      tick();
    end
    idle_in();
    chk1("ovf_full", full, 1'b1);
    chk1("ovf_overflow", overflow, 1'b1);
    chk("ovf_captured", 64'(captured), 64'd16);
    chk("ovf_level", 64'(level), 64'd16);
    bus.rd_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("ovf_rd_fase", bus.rd_fase, 64'(i));
      chk("ovf_rd_cuad", bus.rd_cuad, 64'(i + 100));
    end
    bus.rd_req = 1'b0;
    chk1("ovf_drained_empty", empty, 1'b1);
    chk1("ovf_drained_full", full, 1'b0);
    tick();
    chk1("ovf_rd_valid_low", bus.rd_valid, 1'b0);

    // rd_req while empty is ignored
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk1("emptyrd_rd_valid", bus.rd_valid, 1'b0);
    chk("emptyrd_rd_fase", bus.rd_fase, 64'd16);
    chk("emptyrd_level", 64'(level), 64'd0);

    // Push and pop together while full
    do_clear();
    for (int i = 1; i <= 16; i++) begin
      set_pair(64'(32'h40 + i), 64'(32'h80 + i));
      tick();
    end
    chk1("pp_full_before", full, 1'b1);
    set_pair(64'h55, 64'h66);
    bus.rd_req = 1'b1;
    tick();
    idle_in();
    bus.rd_req = 1'b0;
    chk("pp_level", 64'(level), 64'd16);
    chk1("pp_full", full, 1'b1);
    chk1("pp_overflow", overflow, 1'b0);
    chk("pp_captured", 64'(captured), 64'd17);
    chk1("pp_rd_valid", bus.rd_valid, 1'b1);
    chk("pp_rd_fase", bus.rd_fase, 64'h41);
    bus.rd_req = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      chk("pp_drain", bus.rd_fase, (j < 15) ? 64'(32'h42 + j) : 64'h55);
    end
    bus.rd_req = 1'b0;

    // Frame limit
    do_clear();
    n_frames = 32'd3;
    for (int i = 1; i <= 5; i++) begin
      set_pair(64'(i), 64'(i));
      tick();
      if (i == 2) chk1("frm_done_early", done, 1'b0);
      if (i == 3) begin
        chk1("frm_done_3rd", done, 1'b1);
        chk("frm_captured_3rd", 64'(captured), 64'd3);
      end
    end
    idle_in();
    chk("frm_captured", 64'(captured), 64'd3);
    chk1("frm_overflow", overflow, 1'b0);
    chk("frm_level", 64'(level), 64'd3);
    chk1("frm_done", done, 1'b1);
    n_frames = 32'd0;
    do_clear();
    chk1("frm_done_cleared", done, 1'b0);

    // Pointer wrap over 40 push/pop pairs
    for (int k = 0; k < 40; k++) begin
      set_pair(64'(k), 64'(k * 3));
      tick();
      idle_in();
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      chk("wrap_rd_fase", bus.rd_fase, 64'(k));
      chk("wrap_rd_cuad", bus.rd_cuad, 64'(k * 3));
    end

    // Timestamps: pushes at cycles 10 and 14 after clear
    do_clear();
    repeat (10) tick();
    set_pair(64'hA, 64'hB);
    tick();
    idle_in();
    repeat (3) tick();
    set_pair(64'hC, 64'hD);
    tick();
    idle_in();
    bus.rd_req = 1'b1;
    tick();
    chk("ts_rd_fase0", bus.rd_fase, 64'hA);
    chk("ts_tstamp0", 64'(bus.rd_tstamp), 64'(TS0));
    tick();
    bus.rd_req = 1'b0;
    chk("ts_rd_fase1", bus.rd_fase, 64'hC);
    chk("ts_tstamp1", 64'(bus.rd_tstamp), 64'(TS1));

    // Reset mid-stream clears everything asynchronously
    set_pair(64'd7, 64'd8);
    tick();
    set_pair(64'd9, 64'd10);
    bus.rd_req = 1'b1;
    tick();
    idle_in();
    bus.rd_req = 1'b0;
    chk("mrst_level_before", 64'(level), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mrst_level", 64'(level), 64'd0);
    chk1("mrst_empty", empty, 1'b1);
    chk("mrst_captured", 64'(captured), 64'd0);
    chk1("mrst_rd_valid", bus.rd_valid, 1'b0);
    chk("mrst_rd_fase", bus.rd_fase, 64'd0);
    chk("mrst_rd_tstamp", 64'(bus.rd_tstamp), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    chk1("mrst_lost_rd_valid", bus.rd_valid, 1'b0);
    chk1("mrst_lost_empty", empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
